// File: rtl/mem_port_arbiter.sv
// Arbitrates one downstream line-memory port between the I-side and D-side requesters.
// D wins by default; an I starvation counter forces an I grant once it saturates.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  i_addr,
  input  logic         i_read,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic [31:0]  d_addr,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic [31:0]  mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp,
  input  logic [31:0]  mem_raddr,
  output logic [31:0]  stat_i_grants,
  output logic [31:0]  stat_d_grants,
  output logic [31:0]  stat_orphans,
  output logic [31:0]  stat_starve
);

  localparam int unsigned WCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [31:0]    lat_addr_r;
  logic           lat_read_r;
  logic           lat_write_r;
  logic [255:0]   lat_wdata_r;
  logic [WCW-1:0] wait_cnt_r;
  logic [31:0]    stat_i_r, stat_d_r, stat_orph_r, stat_starve_r;

  logic d_req_s, starve_s, grant_d_s, grant_i_s, hit_s, owner_live_s;
  logic unused_raddr_s;

  assign d_req_s   = d_read | d_write;
  assign starve_s  = (wait_cnt_r >= WCW'(STARVE_LIMIT));
  assign grant_d_s = (state_r == IDLE) & d_req_s & ~(i_read & starve_s);
  assign grant_i_s = (state_r == IDLE) & ~grant_d_s & i_read;
  // Line tag compare: the low 5 bits address bytes within the 32-byte line.
  assign hit_s     = (state_r != IDLE) & mem_resp & (mem_raddr[31:5] == lat_addr_r[31:5]);
  assign unused_raddr_s = ^mem_raddr[4:0];

  assign stat_i_grants = stat_i_r;
  assign stat_d_grants = stat_d_r;
  assign stat_orphans  = stat_orph_r;
  assign stat_starve   = stat_starve_r;

  // Is the owner of the in-flight transaction still asking for it?
  always_comb begin
    owner_live_s = 1'b0;
    case (state_r)
      BUSY_I:  owner_live_s = i_read;
      BUSY_D:  owner_live_s = lat_write_r ? d_write : d_read;
      default: owner_live_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s)      state_s = BUSY_D;
        else if (grant_i_s) state_s = BUSY_I;
        else                state_s = IDLE;
      end
      BUSY_I, BUSY_D: begin
        if (hit_s) state_s = IDLE;
        else       state_s = state_r;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode: mem_* from the latched transaction, responses straight from mem_resp.
  always_comb begin
    mem_read  = (state_r != IDLE) & lat_read_r;
    mem_write = (state_r != IDLE) & lat_write_r;
    mem_addr  = (state_r != IDLE) ? lat_addr_r : 32'd0;
    mem_wdata = ((state_r == BUSY_D) & lat_write_r) ? lat_wdata_r : 256'd0;
    i_resp    = (state_r == BUSY_I) & hit_s & owner_live_s;
    d_resp    = (state_r == BUSY_D) & hit_s & owner_live_s;
    i_rdata   = i_resp ? mem_rdata : 256'd0;
    d_rdata   = (d_resp & lat_read_r) ? mem_rdata : 256'd0;
  end

  // Transaction latch; a D request with both read and write set becomes a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_addr_r  <= 32'd0;
      lat_read_r  <= 1'b0;
      lat_write_r <= 1'b0;
      lat_wdata_r <= 256'd0;
    end else if (grant_d_s) begin
      lat_addr_r  <= d_addr;
      lat_read_r  <= ~d_write;
      lat_write_r <= d_write;
      lat_wdata_r <= d_wdata;
    end else if (grant_i_s) begin
      lat_addr_r  <= i_addr;
      lat_read_r  <= 1'b1;
      lat_write_r <= 1'b0;
      lat_wdata_r <= 256'd0;
    end else begin
      lat_addr_r  <= lat_addr_r;
      lat_read_r  <= lat_read_r;
      lat_write_r <= lat_write_r;
      lat_wdata_r <= lat_wdata_r;
    end
  end

  // I starvation counter, saturating at STARVE_LIMIT.
  always_ff @(posedge clk) begin
    if (!rst_n)                                           wait_cnt_r <= '0;
    else if (!i_read || grant_i_s)                        wait_cnt_r <= '0;
    else if (state_r != BUSY_I && !starve_s)              wait_cnt_r <= wait_cnt_r + WCW'(1);
    else                                                  wait_cnt_r <= wait_cnt_r;
  end

  // Statistics counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_i_r      <= 32'd0;
      stat_d_r      <= 32'd0;
      stat_orph_r   <= 32'd0;
      stat_starve_r <= 32'd0;
    end else begin
      stat_i_r      <= stat_i_r + {31'd0, grant_i_s};
      stat_d_r      <= stat_d_r + {31'd0, grant_d_s};
      stat_orph_r   <= stat_orph_r + {31'd0, hit_s & ~owner_live_s};
      stat_starve_r <= stat_starve_r + {31'd0, grant_i_s & d_req_s & starve_s};
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 8;
  localparam logic [255:0] R1 = {8{32'hDEADBEEF}};
  localparam logic [255:0] R2 = {8{32'h0123CAFE}};
  localparam logic [255:0] R3 = {8{32'h5A5AA5A5}};

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] i_addr, d_addr, mem_addr, mem_raddr;
  logic i_read, i_resp, d_read, d_write, d_resp, mem_read, mem_write, mem_resp;
  logic [255:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [31:0] stat_i_grants, stat_d_grants, stat_orphans, stat_starve;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_raddr(mem_raddr),
    .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
    .stat_orphans(stat_orphans), .stat_starve(stat_starve)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: who owns the port and what was asked for.
  int           m_owner;   // 0 none, 1 I-side, 2 D-side
  logic [31:0]  m_addr;
  bit           m_wr;
  logic [255:0] m_wdata;
  int           m_wait;
  logic [31:0]  m_si, m_sd, m_so, m_ss;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_addr = 32'd0; m_wr = 1'b0; m_wdata = 256'd0; m_wait = 0;
    m_si = 32'd0; m_sd = 32'd0; m_so = 32'd0; m_ss = 32'd0;
  endtask

  function automatic bit m_live();
    if (m_owner == 1) return i_read;
    if (m_owner == 2) return m_wr ? d_write : d_read;
    return 1'b0;
  endfunction

  function automatic bit m_hit();
    return (m_owner != 0) && mem_resp && (mem_raddr[31:5] == m_addr[31:5]);
  endfunction

  task automatic compare_all();
    bit busy, er_i, er_d;
    busy = (m_owner != 0);
    er_i = m_hit() && (m_owner == 1) && m_live();
    er_d = m_hit() && (m_owner == 2) && m_live();
    chk("mem_read", mem_read, busy && !m_wr);
    chk("mem_write", mem_write, busy && m_wr);
    chk("mem_addr", mem_addr, busy ? m_addr : 32'd0);
    chk("mem_wdata", mem_wdata, (m_owner == 2 && m_wr) ? m_wdata : 256'd0);
    chk("i_resp", i_resp, er_i);
    chk("i_rdata", i_rdata, er_i ? mem_rdata : 256'd0);
    chk("d_resp", d_resp, er_d);
    chk("d_rdata", d_rdata, (er_d && !m_wr) ? mem_rdata : 256'd0);
    chk("stat_i_grants", stat_i_grants, m_si);
    chk("stat_d_grants", stat_d_grants, m_sd);
    chk("stat_orphans", stat_orphans, m_so);
    chk("stat_starve", stat_starve, m_ss);
  endtask

  task automatic model_update();
    int  prev;
    bit  dreq, starve, gi;
    if (!rst_n) begin
      model_reset();
    end else begin
      prev = m_owner; dreq = d_read | d_write; starve = (m_wait >= LIMIT); gi = 1'b0;
      if (m_owner != 0) begin
        if (m_hit()) begin
          if (!m_live()) m_so++;
          m_owner = 0;
        end
      end else if (dreq && !(i_read && starve)) begin
        m_owner = 2; m_addr = d_addr; m_wr = d_write; m_wdata = d_wdata; m_sd++;
      end else if (i_read) begin
        m_owner = 1; m_addr = i_addr; m_wr = 1'b0; gi = 1'b1; m_si++;
        if (dreq) m_ss++;
      end
      if (!i_read || gi) m_wait = 0;
      else if (prev != 1) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
    end
  endtask

  task automatic sample_check();
    #3;
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    sample_check();
    advance();
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  typedef struct {
    bit           ir;
    logic [31:0]  ia;
    bit           dr;
    logic [31:0]  da;
    bit           mr;
    logic [31:0]  ra;
    logic [255:0] rd;
    bit           e_mr;
    logic [31:0]  e_ma;
    bit           e_ir;
    bit           e_dr;
    logic [255:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(bit ir, logic [31:0] ia, bit dr, logic [31:0] da, bit mr,
                              logic [31:0] ra, logic [255:0] rd, bit e_mr, logic [31:0] e_ma,
                              bit e_ir, bit e_dr, logic [255:0] e_rdata);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.mr = mr; v.ra = ra; v.rd = rd;
    v.e_mr = e_mr; v.e_ma = e_ma; v.e_ir = e_ir; v.e_dr = e_dr; v.e_rdata = e_rdata;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    bit i_won;
    int dg, busy_cnt, k;

    // lone I read, mismatched tag on D, D withdrawal
    tbl[0]  = mk(1, 32'h1040, 0, 32'h0,    0, 32'h0,    R1, 0, 32'h0,    0, 0, 256'd0);
    tbl[1]  = mk(1, 32'h1040, 0, 32'h0,    0, 32'h0,    R1, 1, 32'h1040, 0, 0, 256'd0);
    tbl[2]  = mk(1, 32'h1040, 0, 32'h0,    1, 32'h1040, R1, 1, 32'h1040, 1, 0, R1);
    tbl[3]  = mk(0, 32'h0,    0, 32'h0,    0, 32'h0,    R1, 0, 32'h0,    0, 0, 256'd0);
    tbl[4]  = mk(0, 32'h0,    1, 32'h3000, 0, 32'h0,    R2, 0, 32'h0,    0, 0, 256'd0);
    tbl[5]  = mk(0, 32'h0,    1, 32'h3000, 1, 32'h2000, R2, 1, 32'h3000, 0, 0, 256'd0);
    tbl[6]  = mk(0, 32'h0,    1, 32'h3000, 1, 32'h3000, R2, 1, 32'h3000, 0, 1, R2);
    tbl[7]  = mk(0, 32'h0,    0, 32'h0,    0, 32'h0,    R2, 0, 32'h0,    0, 0, 256'd0);
    tbl[8]  = mk(0, 32'h0,    1, 32'h4000, 0, 32'h0,    R3, 0, 32'h0,    0, 0, 256'd0);
    tbl[9]  = mk(0, 32'h0,    0, 32'h4000, 0, 32'h0,    R3, 1, 32'h4000, 0, 0, 256'd0);
    tbl[10] = mk(0, 32'h0,    0, 32'h4000, 1, 32'h4000, R3, 1, 32'h4000, 0, 0, 256'd0);
    tbl[11] = mk(0, 32'h0,    0, 32'h0,    0, 32'h0,    R3, 0, 32'h0,    0, 0, 256'd0);

    rst_n = 1'b0; i_addr = 32'd0; i_read = 1'b0; d_addr = 32'd0; d_read = 1'b0; d_write = 1'b0;
    d_wdata = 256'd0; mem_rdata = 256'd0; mem_resp = 1'b0; mem_raddr = 32'd0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    for (int n = 0; n < 12; n++) begin
      i_read = tbl[n].ir; i_addr = tbl[n].ia; d_read = tbl[n].dr; d_addr = tbl[n].da;
      d_write = 1'b0; mem_resp = tbl[n].mr; mem_raddr = tbl[n].ra; mem_rdata = tbl[n].rd;
      sample_check();
      chk("tbl_mem_read", mem_read, tbl[n].e_mr);
      chk("tbl_mem_write", mem_write, 1'b0);
      chk("tbl_mem_addr", mem_addr, tbl[n].e_ma);
      chk("tbl_i_resp", i_resp, tbl[n].e_ir);
      chk("tbl_d_resp", d_resp, tbl[n].e_dr);
      chk("tbl_rdata", i_rdata | d_rdata, tbl[n].e_rdata);
      advance();
    end
    mem_resp = 1'b0;
    chk("tbl_i_grants", stat_i_grants, 32'd1);
    chk("tbl_d_grants", stat_d_grants, 32'd2);
    chk("tbl_orphans", stat_orphans, 32'd1);

    // I read and D write raised together: D first, I after the idle bubble
    i_read = 1'b1; i_addr = 32'h0000_0500;
    d_write = 1'b1; d_addr = 32'h8000_0020; d_wdata = R3;
    sample_check(); chk("t2_idle_write", mem_write, 1'b0); advance();
    sample_check();
    chk("t2_mem_write", mem_write, 1'b1); chk("t2_mem_read", mem_read, 1'b0);
    chk("t2_mem_wdata", mem_wdata, R3); chk("t2_mem_addr", mem_addr, 32'h8000_0020);
    advance();
    mem_resp = 1'b1; mem_raddr = 32'h8000_0020; mem_rdata = R2;
    sample_check();
    chk("t2_d_resp", d_resp, 1'b1); chk("t2_d_rdata", d_rdata, 256'd0); chk("t2_i_resp", i_resp, 1'b0);
    advance();
    d_write = 1'b0; mem_resp = 1'b0;
    sample_check(); chk("t2_bubble", mem_read, 1'b0); advance();
    sample_check();
    chk("t2_i_granted", mem_read, 1'b1); chk("t2_i_addr", mem_addr, 32'h0000_0500);
    chk("t2_i_grants", stat_i_grants, 32'd2); chk("t2_d_grants", stat_d_grants, 32'd3);
    advance();
    mem_resp = 1'b1; mem_raddr = 32'h0000_0500; mem_rdata = R1;
    sample_check(); chk("t2_i_resp_end", i_resp, 1'b1); advance();
    i_read = 1'b0; mem_resp = 1'b0;
    step();

    // Starvation: D continuously requesting, each D round takes 3 cycles
    i_read = 1'b1; i_addr = 32'h0000_7000; d_read = 1'b1; d_addr = 32'h0000_3000;
    i_won = 1'b0; dg = 0; busy_cnt = 0;
    for (int c = 0; c < 60 && !i_won; c++) begin
      if (mem_read || mem_write) begin
        if (mem_addr == 32'h0000_7000) begin
          i_won = 1'b1;
        end else begin
          mem_resp = (busy_cnt == 1); mem_raddr = mem_addr;
          if (busy_cnt == 0) dg++;
          busy_cnt++;
        end
      end else begin
        busy_cnt = 0; mem_resp = 1'b0;
      end
      if (!i_won) step();
    end
    chk("t3_i_granted", i_won, 1'b1);
    chk("t3_d_rounds", dg, (LIMIT + 2) / 3);
    chk("t3_stat_starve", stat_starve, 32'd1);
    mem_resp = 1'b1; mem_raddr = 32'h0000_7000;
    step();
    i_read = 1'b0; d_read = 1'b0; mem_resp = 1'b0;
    step();

    // Reset in the middle of BUSY_I, then a stale response
    i_read = 1'b1; i_addr = 32'h0000_9000;
    step();
    sample_check(); chk("t6_busy", mem_read, 1'b1); advance();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; i_read = 1'b0; mem_resp = 1'b1; mem_raddr = 32'h0000_9000; mem_rdata = R1;
    sample_check();
    chk("t6_mem_read", mem_read, 1'b0); chk("t6_mem_addr", mem_addr, 32'd0);
    chk("t6_i_resp", i_resp, 1'b0); chk("t6_i_grants", stat_i_grants, 32'd0);
    advance();
    mem_resp = 1'b0;
    sample_check(); chk("t6_orphans", stat_orphans, 32'd0); advance();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (!i_read) begin
        if ($urandom_range(0, 2) == 0) begin i_read = 1'b1; i_addr = $urandom; end
      end else if ($urandom_range(0, 19) == 0) begin
        i_read = 1'b0;
      end
      if (!(d_read || d_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, 7);
          d_read = (k < 4) || (k == 7); d_write = (k >= 4);
          d_addr = $urandom; d_wdata = rand256();
        end
      end else if ($urandom_range(0, 19) == 0) begin
        d_read = 1'b0; d_write = 1'b0;
      end
      mem_rdata = rand256();
      if (mem_read || mem_write) begin
        mem_resp = ($urandom_range(0, 2) == 0);
        mem_raddr = ($urandom_range(0, 5) != 0) ? {mem_addr[31:5], 5'($urandom)} : 32'($urandom);
      end else begin
        mem_resp = ($urandom_range(0, 19) == 0);
        mem_raddr = $urandom;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
